// File: rtl/sram_be_ctrl.sv
// rtl/sram_be_ctrl.sv - single-port SRAM with byte enables, registered read, ready handshake and post-reset clear
module sram_be_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_SIZE       = 1 << ADDR_WIDTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    chip_enable_n,
    input  logic                    write_enable_n,
    input  logic                    read_enable_n,
    input  logic [DATA_WIDTH/8-1:0] byte_enable_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    ready,
    output logic                    addr_error,
    output logic                    cmd_error
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDR_WIDTH:0]   SIZE_EXT  = (ADDR_WIDTH + 1)'(MEM_SIZE);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : IDLE;

    state_t current_state, next_state;

    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  addr_error_q, addr_error_d;
    logic                  cmd_error_q, cmd_error_d;
    logic                  ready_q, ready_d;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    logic                  selected, wr_cmd, rd_cmd, both_cmd, in_range;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_lane_n;
    logic [IDX_W-1:0]      mem_idx, rd_idx;

    assign selected = ready_q && !chip_enable_n;
    assign wr_cmd   = selected && !write_enable_n && read_enable_n;
    assign rd_cmd   = selected && write_enable_n && !read_enable_n;
    assign both_cmd = selected && !write_enable_n && !read_enable_n;
    assign in_range = ({1'b0, address} < SIZE_EXT);
    assign mem_idx  = mem_addr[IDX_W-1:0];
    assign rd_idx   = address[IDX_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            current_state <= RESET_STATE;
            clr_cnt_q     <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            addr_error_q  <= 1'b0;
            cmd_error_q   <= 1'b0;
            ready_q       <= (RESET_STATE != INIT);
        end else begin
            current_state <= next_state;
            clr_cnt_q     <= clr_cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            addr_error_q  <= addr_error_d;
            cmd_error_q   <= cmd_error_d;
            ready_q       <= ready_d;
        end
    end

    always_comb begin
        next_state = current_state;
        clr_cnt_d  = clr_cnt_q;
        if (current_state == INIT) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_WORD) begin
                next_state = IDLE;
                clr_cnt_d  = '0;
            end
        end else if (wr_cmd) begin
            next_state = WRITE;
        end else if (rd_cmd) begin
            next_state = READ;
        end else begin
            next_state = IDLE;
        end
    end

    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        addr_error_d = (wr_cmd || rd_cmd) && !in_range;
        cmd_error_d  = both_cmd;
        ready_d      = (next_state != INIT);
        if (rd_cmd) begin
            data_out_d   = in_range ? mem[rd_idx] : '0;
            data_valid_d = 1'b1;
        end
    end

    // The clear sweep shares the single write port with normal writes.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = address;
        mem_wdata  = data_in;
        mem_lane_n = byte_enable_n;
        if (current_state == INIT) begin
            mem_we     = 1'b1;
            mem_addr   = clr_cnt_q;
            mem_wdata  = '0;
            mem_lane_n = '0;
        end else if (wr_cmd && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (!mem_lane_n[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign addr_error = addr_error_q;
    assign cmd_error  = cmd_error_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_sram_be_ctrl.sv
// tb/tb_sram_be_ctrl.sv - table vectors, reset/clear sequences and random traffic against a word-array model
module tb_sram_be_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MS = 200;
    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          chip_enable_n = 1'b1;
    logic          write_enable_n = 1'b1;
    logic          read_enable_n = 1'b1;
    logic [3:0]    byte_enable_n = 4'hF;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          data_valid, ready, addr_error, cmd_error;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [MS];
    logic [31:0] m_dout;

    typedef struct {
        logic        ce, we, re;
        logic [3:0]  be;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] dout;
        logic        valid, aerr, cerr;
    } vec_t;

    vec_t vecs[16];

    sram_be_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .chip_enable_n(chip_enable_n),
        .write_enable_n(write_enable_n), .read_enable_n(read_enable_n),
        .byte_enable_n(byte_enable_n), .address(address), .data_in(data_in),
        .data_out(data_out), .data_valid(data_valid), .ready(ready),
        .addr_error(addr_error), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic ce, logic we, logic re, logic [3:0] be, logic [7:0] a,
                                logic [31:0] d, logic [31:0] dout, logic v, logic ae, logic cerr);
        vec_t t;
        t.ce = ce; t.we = we; t.re = re; t.be = be; t.addr = a; t.data = d;
        t.dout = dout; t.valid = v; t.aerr = ae; t.cerr = cerr;
        return t;
    endfunction

    task automatic drive(input logic ce, input logic we, input logic re, input logic [3:0] be,
                         input logic [7:0] a, input logic [31:0] d);
        chip_enable_n = ce; write_enable_n = we; read_enable_n = re;
        byte_enable_n = be; address = a; data_in = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < MS; i++) ref_mem[i] = '0;
        m_dout = '0;
    endtask

    // Word-array reference: one accepted command per cycle, lanes merged through a byte mask.
    task automatic model(input logic ce, input logic we, input logic re, input logic [3:0] be,
                         input logic [7:0] a, input logic [31:0] d,
                         output logic [31:0] e_dout, output logic e_v, output logic e_ae, output logic e_ce);
        logic [31:0] mask;
        int          ai;
        e_v = 1'b0; e_ae = 1'b0; e_ce = 1'b0;
        ai = int'(a);
        if (!ce && (we != re)) begin
            if (!we) begin
                if (ai < MS) begin
                    for (int i = 0; i < 4; i++) mask[8*i +: 8] = be[i] ? 8'h00 : 8'hFF;
                    ref_mem[ai] = (ref_mem[ai] & ~mask) | (d & mask);
                end else begin
                    e_ae = 1'b1;
                end
            end else begin
                e_v    = 1'b1;
                e_ae   = (ai >= MS);
                m_dout = (ai < MS) ? ref_mem[ai] : 32'h0;
            end
        end else if (!ce && !we && !re) begin
            e_ce = 1'b1;
        end
        e_dout = m_dout;
    endtask

    task automatic step(input string tag, input logic ce, input logic we, input logic re,
                        input logic [3:0] be, input logic [7:0] a, input logic [31:0] d);
        logic [31:0] e_dout;
        logic        e_v, e_ae, e_ce;
        drive(ce, we, re, be, a, d);
        model(ce, we, re, be, a, d, e_dout, e_v, e_ae, e_ce);
        @(posedge clk); #1;
        chk({tag, "_dout"}, data_out, e_dout);
        chk({tag, "_valid"}, 32'(data_valid), 32'(e_v));
        chk({tag, "_aerr"}, 32'(addr_error), 32'(e_ae));
        chk({tag, "_cerr"}, 32'(cmd_error), 32'(e_ce));
        chk({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_init_cycles"}, 32'(n), 32'd200);
        chk({tag, "_state_idle"}, 32'(dut.current_state), 32'(ST_IDLE));
        model_clear();
    endtask

    initial begin
        // Reset and full clear sweep; a write held during the sweep must be dropped.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", data_out, 32'h0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_state", 32'(dut.current_state), 32'(ST_INIT));
        drive(1'b0, 1'b0, 1'b1, 4'h0, 8'h40, 32'hFFFF_FFFF);
        reset_n = 1'b1;
        wait_ready("first");

        vecs[0]  = mk(0, 1, 0, 4'hF, 8'h50, 32'h0,         32'h0000_0000, 1, 0, 0);
        vecs[1]  = mk(0, 1, 0, 4'hF, 8'h40, 32'h0,         32'h0000_0000, 1, 0, 0);
        vecs[2]  = mk(0, 0, 1, 4'h0, 8'h05, 32'hDEAD_BEEF, 32'h0000_0000, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 4'hA, 8'h05, 32'h1122_3344, 32'h0000_0000, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 4'hF, 8'h05, 32'h0,         32'hDE22_BE44, 1, 0, 0);
        vecs[5]  = mk(0, 0, 1, 4'h0, 8'h30, 32'hA5A5_A5A5, 32'hDE22_BE44, 0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 4'h0, 8'h30, 32'h0,         32'hA5A5_A5A5, 1, 0, 0);
        vecs[7]  = mk(0, 0, 1, 4'h0, 8'd199, 32'h1234_5678, 32'hA5A5_A5A5, 0, 0, 0);
        vecs[8]  = mk(0, 1, 0, 4'h0, 8'd199, 32'h0,        32'h1234_5678, 1, 0, 0);
        vecs[9]  = mk(0, 0, 1, 4'h0, 8'd200, 32'hFFFF_FFFF, 32'h1234_5678, 0, 1, 0);
        vecs[10] = mk(0, 1, 0, 4'h0, 8'd200, 32'h0,        32'h0000_0000, 1, 1, 0);
        vecs[11] = mk(0, 1, 0, 4'h0, 8'h00, 32'h0,         32'h0000_0000, 1, 0, 0);
        vecs[12] = mk(0, 0, 0, 4'h0, 8'h20, 32'h7777_7777, 32'h0000_0000, 0, 0, 1);
        vecs[13] = mk(0, 1, 0, 4'h0, 8'h20, 32'h0,         32'h0000_0000, 1, 0, 0);
        vecs[14] = mk(1, 0, 1, 4'h0, 8'h20, 32'h5555_5555, 32'h0000_0000, 0, 0, 0);
        vecs[15] = mk(0, 1, 0, 4'h0, 8'h20, 32'h0,         32'h0000_0000, 1, 0, 0);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] e_dout;
            logic        e_v, e_ae, e_ce;
            drive(vecs[i].ce, vecs[i].we, vecs[i].re, vecs[i].be, vecs[i].addr, vecs[i].data);
            model(vecs[i].ce, vecs[i].we, vecs[i].re, vecs[i].be, vecs[i].addr, vecs[i].data,
                  e_dout, e_v, e_ae, e_ce);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_dout", i), data_out, vecs[i].dout);
            chk($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_aerr", i), 32'(addr_error), 32'(vecs[i].aerr));
            chk($sformatf("vec%0d_cerr", i), 32'(cmd_error), 32'(vecs[i].cerr));
            chk($sformatf("vec%0d_ready", i), 32'(ready), 32'd1);
            if (vecs[i].cerr) chk($sformatf("vec%0d_state", i), 32'(dut.current_state), 32'(ST_IDLE));
        end

        // Error pulses last exactly one cycle.
        step("idle_after_err", 1'b1, 1'b1, 1'b1, 4'h0, 8'h00, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 $urandom);
        end

        // Reset asserted mid-operation, coinciding with a write command.
        step("pre_wr", 1'b0, 1'b0, 1'b1, 4'h0, 8'd10, 32'hCAFE_F00D);
        step("pre_rd", 1'b0, 1'b1, 1'b0, 4'h0, 8'd10, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 4'h0, 8'd11, 32'h1357_9BDF);
        reset_n = 1'b0;
        #1;
        chk("midop_dout", data_out, 32'h0);
        chk("midop_valid", 32'(data_valid), 32'd0);
        chk("midop_ready", 32'(ready), 32'd0);
        chk("midop_state", 32'(dut.current_state), 32'(ST_INIT));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_ready("midop");
        step("clr_rd10", 1'b0, 1'b1, 1'b0, 4'h0, 8'd10, 32'h0);
        step("clr_rd11", 1'b0, 1'b1, 1'b0, 4'h0, 8'd11, 32'h0);
        step("wr_pre_init", 1'b0, 1'b0, 1'b1, 4'h0, 8'd150, 32'h0BAD_CAFE);

        // Reset asserted at cycle 50 of the sweep restarts it from word 0.
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 4'hF, 8'h0, 32'h0);
        repeat (50) @(posedge clk);
        #1;
        chk("midinit_ready_before", 32'(ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("midinit_ready", 32'(ready), 32'd0);
        chk("midinit_state", 32'(dut.current_state), 32'(ST_INIT));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_ready("midinit");
        step("midinit_rd150", 1'b0, 1'b1, 1'b0, 4'h0, 8'd150, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
